// File: rtl/crossbar_loader_pkg.sv
// Shared crossbar definitions: loader FSM state encodings.
`ifndef CROSSBAR_LOADER_PKG_SV
`define CROSSBAR_LOADER_PKG_SV
package crossbar_loader_pkg;

  // IDLE waits for start, CLEAR wipes every column, LOAD streams route entries.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2
  } xbl_state_e;

endpackage
`endif

// File: rtl/crossbar_loader.sv
// Crossbar route loader: on start, clears all OUT columns (one command per
// cycle), then forwards legal route entries as registered crossbar commands.
// Illegal entries are dropped and flagged in a sticky err bit.
module crossbar_loader
  import crossbar_loader_pkg::*;
#(
  parameter int W   = 8,
  parameter int IN  = 8,
  parameter int OUT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_from,
  input  logic        [W-1:0] s_to,
  input  logic                s_last,
  output logic signed [W-1:0] from,
  output logic        [W-1:0] to,
  output logic                put,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CW = (OUT > 1) ? $clog2(OUT) : 1;
  // Bounds widened by one bit so an all-ones s_to or max-positive s_from
  // cannot alias a legal index.
  localparam logic signed [W:0] IN_X     = (W+1)'(IN);
  localparam logic        [W:0] OUT_X    = (W+1)'(OUT);
  localparam logic     [CW-1:0] LAST_COL = CW'(OUT - 1);

  xbl_state_e    r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          w_xfer, w_legal, w_from_ok, w_to_ok;

  assign s_ready   = (r_state == ST_LOAD);
  assign busy      = (r_state != ST_IDLE);
  assign w_xfer    = s_valid & s_ready;
  // Negative sources are column clears and always pass the signed compare.
  assign w_from_ok = $signed({s_from[W-1], s_from}) < IN_X;
  assign w_to_ok   = {1'b0, s_to} < OUT_X;
  assign w_legal   = w_from_ok & w_to_ok;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; CLEAR exits after the command for the last column.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_CLEAR;
      ST_CLEAR: if (r_cnt == LAST_COL) w_next = ST_LOAD;
      ST_LOAD:  if (w_xfer && s_last) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Registered command outputs, column counter and sticky error.
  // r_cnt always holds the column whose clear command is currently on 'to',
  // so the first clear goes out the cycle after start is sampled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      put   <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      from  <= '0;
      to    <= '0;
    end else begin
      put  <= 1'b0;
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            err   <= 1'b0;
            put   <= 1'b1;
            from  <= '1;
            to    <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_cnt != LAST_COL) begin
            r_cnt <= r_cnt + 1'b1;
            put   <= 1'b1;
            from  <= '1;
            to    <= W'(r_cnt) + W'(1);
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            done <= s_last;
            if (w_legal) begin
              put  <= 1'b1;
              from <= s_from;
              to   <= s_to;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
